// File: rtl/ctrl_decode_stage_if.sv
// Interface bundling the decode stage's upstream handshake, downstream handshake,
// registered control bundle and performance counters.
interface ctrl_decode_stage_if #(
  parameter int OP_W = 8,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [RA_W-1:0] ra;
  logic [RA_W-1:0] rb;
  logic [RA_W-1:0] rd;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [RA_W-1:0] out_rd;
  logic [1:0]      alu_src;
  logic [3:0]      alu_op;
  logic            alu_op2;
  logic [1:0]      branch_flag;
  logic            jump_flag;
  logic            mem_sign_extend;
  logic            pc_src;
  logic [3:0]      mem_read;
  logic [3:0]      mem_write;
  logic            rb_select;
  logic [1:0]      mem_to_reg;
  logic            reg_write;
  logic [15:0]     stall_cnt;
  logic [15:0]     flush_cnt;

  modport slave (
    input  in_valid, op, ra, rb, rd, flush, out_ready,
    output in_ready, out_valid, out_rd, alu_src, alu_op, alu_op2, branch_flag,
           jump_flag, mem_sign_extend, pc_src, mem_read, mem_write, rb_select,
           mem_to_reg, reg_write, stall_cnt, flush_cnt
  );

  modport master (
    output in_valid, op, ra, rb, rd, flush, out_ready,
    input  in_ready, out_valid, out_rd, alu_src, alu_op, alu_op2, branch_flag,
           jump_flag, mem_sign_extend, pc_src, mem_read, mem_write, rb_select,
           mem_to_reg, reg_write, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered opcode decode stage: valid/ready pipeline register, load-use bubbles,
// multi-cycle multiply sequencing and flush. Define CTRL_DECODE_PERF_EN for stall/flush counters.
module ctrl_decode_stage #(
  parameter int OP_W       = 8,
  parameter int RA_W       = 5,
  parameter int MUL_CYCLES = 3
) (
  input logic                clk,
  input logic                reset,
  ctrl_decode_stage_if.slave bus
);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [3:0] alu_op;
    logic       alu_op2;
    logic [1:0] branch_flag;
    logic       jump_flag;
    logic       mem_sign_extend;
    logic       pc_src;
    logic [3:0] mem_read;
    logic [3:0] mem_write;
    logic       rb_select;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef enum logic {RUN, MULWAIT} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t           bundle_q, bundle_d, dec;
  logic            valid_q, valid_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            load_en, hazard, ready, is_mul, op_hi_set;
  logic [7:0]      op_lo;

  assign op_lo     = bus.op[7:0];
  assign op_hi_set = (bus.op >> 8) != '0;

  always_comb begin
    dec    = '0;
    is_mul = 1'b0;
    if (!op_hi_set) begin
      case (op_lo)
        8'h08, 8'h10, 8'h18, 8'h28, 8'h30, 8'h38, 8'h40, 8'h48, 8'h50, 8'h58, 8'h07: begin
          dec.mem_to_reg = 2'b01;
          dec.reg_write  = 1'b1;
        end
        8'h03, 8'h0B, 8'h13, 8'h23, 8'h1B, 8'h2B, 8'h33: begin
          dec.alu_src    = 2'b01;
          dec.mem_to_reg = 2'b01;
          dec.reg_write  = 1'b1;
        end
        8'h19, 8'h11, 8'h09: begin
          dec.alu_src   = 2'b01;
          dec.rb_select = 1'b1;
        end
        8'h31, 8'h29, 8'h21, 8'h51, 8'h49: begin
          dec.alu_src   = 2'b01;
          dec.rb_select = 1'b1;
          dec.reg_write = 1'b1;
        end
        8'h39, 8'h41: dec.rb_select = 1'b1;
        8'h04: begin
          dec.jump_flag  = 1'b1;
          dec.mem_to_reg = 2'b10;
          dec.reg_write  = 1'b1;
          dec.pc_src     = 1'b1;
        end
        default: ;
      endcase
      case (op_lo)
        8'h10, 8'h0B, 8'h39, 8'h41: dec.alu_op = 4'd1;
        8'h18, 8'h07, 8'h13:        dec.alu_op = 4'd2;
        8'h38, 8'h23:               dec.alu_op = 4'd3;
        8'h30, 8'h1B:               dec.alu_op = 4'd4;
        8'h28, 8'h2B:               dec.alu_op = 4'd5;
        8'h48:                      dec.alu_op = 4'd6;
        8'h58:                      dec.alu_op = 4'd7;
        8'h50:                      dec.alu_op = 4'd8;
        8'h40, 8'h33:               dec.alu_op = 4'd9;
        default: ;
      endcase
      case (op_lo)
        8'h19: dec.mem_write = 4'b1111;
        8'h11: dec.mem_write = 4'b0011;
        8'h09: dec.mem_write = 4'b0001;
        8'h31: dec.mem_read  = 4'b1111;
        8'h29: dec.mem_read  = 4'b0011;
        8'h21: dec.mem_read  = 4'b0001;
        8'h51: begin dec.mem_read = 4'b0011; dec.mem_sign_extend = 1'b1; end
        8'h49: begin dec.mem_read = 4'b0001; dec.mem_sign_extend = 1'b1; end
        8'h39: dec.branch_flag = 2'b01;
        8'h41: dec.branch_flag = 2'b10;
        8'h07: dec.alu_op2 = 1'b1;
        default: ;
      endcase
      is_mul = (op_lo == 8'h18) || (op_lo == 8'h07) || (op_lo == 8'h13);
    end
  end

  // The hazard compare ignores rb_select on purpose: a false bubble is cheaper than a decode dependency.
  assign load_en = bus.out_ready | ~valid_q;
  assign hazard  = valid_q && (bundle_q.mem_read != '0) && (rd_q != '0) &&
                   ((rd_q == bus.ra) || (rd_q == bus.rb));
  assign ready   = load_en && (state_q == RUN) && !hazard && !bus.flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    if (bus.flush) begin
      state_d  = RUN;
      cnt_d    = '0;
      bundle_d = '0;
      valid_d  = 1'b0;
      rd_d     = '0;
    end else if (state_q == MULWAIT) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (load_en) begin
      if (hazard) begin
        bundle_d = '0;
        valid_d  = 1'b1;
        rd_d     = '0;
      end else if (bus.in_valid) begin
        bundle_d = dec;
        rd_d     = bus.rd;
        valid_d  = 1'b1;
        if (is_mul && (MUL_CYCLES > 1)) begin
          state_d = MULWAIT;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          valid_d = 1'b0;
        end
      end else begin
        bundle_d = '0;
        valid_d  = 1'b0;
        rd_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      bundle_q <= '0;
      valid_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.in_ready        = ready;
  assign bus.out_valid       = valid_q;
  assign bus.out_rd          = rd_q;
  assign bus.alu_src         = bundle_q.alu_src;
  assign bus.alu_op          = bundle_q.alu_op;
  assign bus.alu_op2         = bundle_q.alu_op2;
  assign bus.branch_flag     = bundle_q.branch_flag;
  assign bus.jump_flag       = bundle_q.jump_flag;
  assign bus.mem_sign_extend = bundle_q.mem_sign_extend;
  assign bus.pc_src          = bundle_q.pc_src;
  assign bus.mem_read        = bundle_q.mem_read;
  assign bus.mem_write       = bundle_q.mem_write;
  assign bus.rb_select       = bundle_q.rb_select;
  assign bus.mem_to_reg      = bundle_q.mem_to_reg;
  assign bus.reg_write       = bundle_q.reg_write;

`ifdef CTRL_DECODE_PERF_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (bus.in_valid && !ready && !bus.flush && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (bus.flush && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: opcode table sweep, hand-written pipeline
// corner sequences and randomized traffic checked against a cycle-level reference model.
module tb_ctrl_decode_stage;
  localparam int OP_W       = 8;
  localparam int RA_W       = 5;
  localparam int MUL_CYCLES = 3;
`ifdef CTRL_DECODE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ctrl_decode_stage_if #(.OP_W(OP_W), .RA_W(RA_W)) bus ();

  ctrl_decode_stage #(.OP_W(OP_W), .RA_W(RA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] bundle;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] exp_tab [256];
  logic [7:0]  picks [13];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Bundle packing order: alu_src, alu_op, alu_op2, branch_flag, jump_flag,
  // mem_sign_extend, pc_src, mem_read, mem_write, rb_select, mem_to_reg, reg_write.
  function automatic logic [23:0] mk(int src, int alu, int op2, int br, int jmp, int sext,
                                     int pcs, int mr, int mw, int rbs, int m2r, int rw);
    return {2'(src), 4'(alu), 1'(op2), 2'(br), 1'(jmp), 1'(sext), 1'(pcs),
            4'(mr), 4'(mw), 1'(rbs), 2'(m2r), 1'(rw)};
  endfunction

  function automatic logic [23:0] dut_bundle();
    return {bus.alu_src, bus.alu_op, bus.alu_op2, bus.branch_flag, bus.jump_flag,
            bus.mem_sign_extend, bus.pc_src, bus.mem_read, bus.mem_write, bus.rb_select,
            bus.mem_to_reg, bus.reg_write};
  endfunction

  function automatic bit is_mul_op(logic [7:0] o);
    return (o == 8'h18) || (o == 8'h07) || (o == 8'h13);
  endfunction

  task automatic add(input logic [7:0] o, input logic [23:0] b);
    vec_t v;
    v.op = o;
    v.bundle = b;
    vecs.push_back(v);
  endtask

  task automatic fill_table();
    //    op        src alu op2 br jmp sx pc  mr  mw rbs m2r rw
    add(8'h08, mk(0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h10, mk(0, 1, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h18, mk(0, 2, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h28, mk(0, 5, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h30, mk(0, 4, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h38, mk(0, 3, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h40, mk(0, 9, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h48, mk(0, 6, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h50, mk(0, 8, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h58, mk(0, 7, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h07, mk(0, 2, 1, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h03, mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h0B, mk(1, 1, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h13, mk(1, 2, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h23, mk(1, 3, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h1B, mk(1, 4, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h2B, mk(1, 5, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h33, mk(1, 9, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1));
    add(8'h19, mk(1, 0, 0, 0, 0, 0, 0,  0, 15, 1, 0, 0));
    add(8'h11, mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 0, 0));
    add(8'h09, mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0));
    add(8'h31, mk(1, 0, 0, 0, 0, 0, 0, 15,  0, 1, 0, 1));
    add(8'h29, mk(1, 0, 0, 0, 0, 0, 0,  3,  0, 1, 0, 1));
    add(8'h21, mk(1, 0, 0, 0, 0, 0, 0,  1,  0, 1, 0, 1));
    add(8'h51, mk(1, 0, 0, 0, 0, 1, 0,  3,  0, 1, 0, 1));
    add(8'h49, mk(1, 0, 0, 0, 0, 1, 0,  1,  0, 1, 0, 1));
    add(8'h39, mk(0, 1, 0, 1, 0, 0, 0,  0,  0, 1, 0, 0));
    add(8'h41, mk(0, 1, 0, 2, 0, 0, 0,  0,  0, 1, 0, 0));
    add(8'h04, mk(0, 0, 0, 0, 1, 0, 1,  0,  0, 0, 2, 1));
    for (int i = 0; i < 256; i++) exp_tab[i] = '0;
    foreach (vecs[i]) exp_tab[vecs[i].op] = vecs[i].bundle;
    picks = '{8'h31, 8'h29, 8'h21, 8'h51, 8'h49, 8'h08, 8'h18, 8'h07, 8'h13,
              8'h19, 8'h39, 8'h04, 8'h10};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] o, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d, input logic fl,
                               input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.op        = o;
    bus.ra        = a;
    bus.rb        = b;
    bus.rd        = d;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  // Reference model: what the stage holds, how many cycles a multiply still owes,
  // and the counters, advanced once per clock from the inputs seen at the edge.
  logic        m_live = 1'b0;
  logic        m_valid = 1'b0;
  logic [23:0] m_bundle = '0;
  logic [4:0]  m_rd = '0;
  int          m_wait = 0;
  int          m_stall = 0;
  int          m_flush = 0;

  function automatic logic model_hazard();
    return m_valid && (m_bundle[11:8] != 4'd0) && (m_rd != 5'd0) &&
           ((m_rd == bus.ra) || (m_rd == bus.rb));
  endfunction

  function automatic logic model_ready();
    return (m_wait == 0) && (bus.out_ready || !m_valid) && !model_hazard() && !bus.flush;
  endfunction

  always @(posedge clk) begin
    logic rdy, hz;
    rdy = model_ready();
    hz  = model_hazard();
    if (reset) begin
      m_live = 1'b1; m_valid = 1'b0; m_bundle = '0; m_rd = '0;
      m_wait = 0; m_stall = 0; m_flush = 0;
    end else if (m_live) begin
      if (bus.in_valid && !rdy && !bus.flush && m_stall < 65535) m_stall++;
      if (bus.flush && m_flush < 65535) m_flush++;
      if (bus.flush) begin
        m_valid = 1'b0; m_bundle = '0; m_rd = '0; m_wait = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1'b1;
      end else if (bus.out_ready || !m_valid) begin
        if (hz) begin
          m_valid = 1'b1; m_bundle = '0; m_rd = '0;
        end else if (bus.in_valid) begin
          m_bundle = exp_tab[bus.op];
          m_rd     = bus.rd;
          m_wait   = is_mul_op(bus.op) ? MUL_CYCLES - 1 : 0;
          m_valid  = (m_wait == 0);
        end else begin
          m_valid = 1'b0; m_bundle = '0; m_rd = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (m_live) begin
      checkOutput("model in_ready", 32'(bus.in_ready), 32'(model_ready()));
      checkOutput("model out_valid", 32'(bus.out_valid), 32'(m_valid));
      checkOutput("model out_rd", 32'(bus.out_rd), 32'(m_rd));
      checkOutput("model bundle", 32'(dut_bundle()), 32'(m_bundle));
      checkOutput("model stall_cnt", 32'(bus.stall_cnt), PERF ? m_stall : 0);
      checkOutput("model flush_cnt", 32'(bus.flush_cnt), PERF ? m_flush : 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [7:0] o;
    fill_table();
    bus.in_valid = 1'b0; bus.op = '0; bus.ra = '0; bus.rb = '0; bus.rd = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;

    // Reset held for two edges; everything must read zero.
    for (int i = 0; i < 2; i++) begin
      idle();
      checkOutput("reset out_valid", 32'(bus.out_valid), 0);
      checkOutput("reset bundle", 32'(dut_bundle()), 0);
      checkOutput("reset out_rd", 32'(bus.out_rd), 0);
      checkOutput("reset counters", {bus.stall_cnt, bus.flush_cnt}, 0);
    end
    reset = 1'b0;

    applyStimulus(1'b1, 8'h08, 5'd1, 5'd2, 5'd2, 1'b0, 1'b1);
    checkOutput("add in_ready", 32'(bus.in_ready), 1);
    idle();
    checkOutput("add out_valid", 32'(bus.out_valid), 1);
    checkOutput("add alu_op", 32'(bus.alu_op), 0);
    checkOutput("add mem_to_reg", 32'(bus.mem_to_reg), 1);
    checkOutput("add reg_write", 32'(bus.reg_write), 1);
    checkOutput("add out_rd", 32'(bus.out_rd), 2);

    // Load-use: LW rd=3 followed by ADD reading r3.
    applyStimulus(1'b1, 8'h31, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    checkOutput("lw in_ready", 32'(bus.in_ready), 1);
    applyStimulus(1'b1, 8'h08, 5'd3, 5'd0, 5'd4, 1'b0, 1'b1);
    checkOutput("lw mem_read", 32'(bus.mem_read), 32'hF);
    checkOutput("hazard in_ready", 32'(bus.in_ready), 0);
    applyStimulus(1'b1, 8'h08, 5'd3, 5'd0, 5'd4, 1'b0, 1'b1);
    checkOutput("bubble out_valid", 32'(bus.out_valid), 1);
    checkOutput("bubble bundle", 32'(dut_bundle()), 0);
    checkOutput("after bubble in_ready", 32'(bus.in_ready), 1);
    idle();
    checkOutput("post-bubble add", 32'(dut_bundle()), 32'(exp_tab[8'h08]));
    checkOutput("post-bubble out_rd", 32'(bus.out_rd), 4);

    applyStimulus(1'b1, 8'h31, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h08, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    checkOutput("rd0 no hazard in_ready", 32'(bus.in_ready), 1);
    idle();
    checkOutput("rd0 add direct", 32'(dut_bundle()), 32'(exp_tab[8'h08]));

    // Multiply occupancy for MUL then MULA.
    for (int m = 0; m < 2; m++) begin
      o = (m == 0) ? 8'h18 : 8'h07;
      applyStimulus(1'b1, o, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
      checkOutput("mul in_ready", 32'(bus.in_ready), 1);
      for (int i = 1; i < MUL_CYCLES; i++) begin
        idle();
        checkOutput("mulwait out_valid", 32'(bus.out_valid), 0);
        checkOutput("mulwait in_ready", 32'(bus.in_ready), 0);
      end
      idle();
      checkOutput("mul out_valid", 32'(bus.out_valid), 1);
      checkOutput("mul alu_op", 32'(bus.alu_op), 2);
      checkOutput("mul alu_op2", 32'(bus.alu_op2), (m == 0) ? 0 : 1);
      checkOutput("mul out_rd", 32'(bus.out_rd), 5);
      checkOutput("mul done in_ready", 32'(bus.in_ready), 1);
    end

    // Backpressure with SW held.
    applyStimulus(1'b1, 8'h19, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h19, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("bp in_ready", 32'(bus.in_ready), 0);
      checkOutput("bp out_valid", 32'(bus.out_valid), 1);
      checkOutput("bp mem_write", 32'(bus.mem_write), 32'hF);
    end
    idle();
    checkOutput("bp held sw", 32'(dut_bundle()), 32'(exp_tab[8'h19]));

    // Reset in the middle of a multiply.
    applyStimulus(1'b1, 8'h18, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
    idle();
    checkOutput("mulwait before reset", 32'(bus.in_ready), 0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checkOutput("reset mul out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset mul bundle", 32'(dut_bundle()), 0);
    checkOutput("reset mul in_ready", 32'(bus.in_ready), 1);

    // Flush during a multiply, then flush colliding with a load-use hazard.
    applyStimulus(1'b1, 8'h18, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    checkOutput("flush in_ready", 32'(bus.in_ready), 0);
    idle();
    checkOutput("flush out_valid", 32'(bus.out_valid), 0);
    checkOutput("flush bundle", 32'(dut_bundle()), 0);
    checkOutput("flush in_ready after", 32'(bus.in_ready), 1);
    checkOutput("flush flush_cnt", 32'(bus.flush_cnt), PERF ? 1 : 0);
    checkOutput("flush stall_cnt", 32'(bus.stall_cnt), 0);
    applyStimulus(1'b1, 8'h31, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h08, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1);
    checkOutput("flush+hazard in_ready", 32'(bus.in_ready), 0);
    idle();
    checkOutput("flush+hazard no bubble", 32'(bus.out_valid), 0);
    checkOutput("flush+hazard bundle", 32'(dut_bundle()), 0);

    // Opcode sweep against the decode table.
    for (int op = 0; op < 256; op++) begin
      applyStimulus(1'b1, 8'(op), 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      k = 0;
      while (!bus.in_ready && k < 8) begin
        applyStimulus(1'b1, 8'(op), 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        k++;
      end
      checkOutput("sweep accept", 32'(bus.in_ready), 1);
      idle();
      k = 0;
      while (!bus.out_valid && k < 2 * MUL_CYCLES) begin
        idle();
        k++;
      end
      checkOutput("sweep out_valid", 32'(bus.out_valid), 1);
      checkOutput($sformatf("sweep op %02h", op), 32'(dut_bundle()), 32'(exp_tab[op]));
    end

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 13);
      o = (r == 13) ? 8'($urandom_range(0, 255)) : picks[r];
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(($urandom_range(0, 3) != 0), o, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    reset = 1'b0;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
